// File: rtl/fpu_share_arbiter_if.sv
// Bundle between client requesters, the shared-FPU arbiter and the FPU itself.
// The slave modport is the arbiter's view; master is the clients-plus-FPU side.
interface fpu_share_arbiter_if #(
  parameter int REG_SIZE = 32,
  parameter int OP_BITS  = 2,
  parameter int NREQ     = 4
);
  logic [NREQ-1:0]                req_valid;
  logic [NREQ-1:0][OP_BITS-1:0]   req_op;
  logic [NREQ-1:0][REG_SIZE-1:0]  req_a;
  logic [NREQ-1:0][REG_SIZE-1:0]  req_b;
  logic [NREQ-1:0]                req_ack;
  logic [NREQ-1:0]                rsp_valid;
  logic [REG_SIZE-1:0]            rsp_res;
  logic                           rsp_err;
  logic [5:0]                     rsp_cycles;
  logic                           busy;
  logic                           fpu_start;
  logic [OP_BITS-1:0]             fpu_operation;
  logic [REG_SIZE-1:0]            fpu_inpA;
  logic [REG_SIZE-1:0]            fpu_inpB;
  logic [REG_SIZE-1:0]            fpu_res;
  logic                           fpu_ready;

  modport slave (
    input  req_valid, req_op, req_a, req_b, fpu_res, fpu_ready,
    output req_ack, rsp_valid, rsp_res, rsp_err, rsp_cycles, busy,
           fpu_start, fpu_operation, fpu_inpA, fpu_inpB
  );

  modport master (
    output req_valid, req_op, req_a, req_b, fpu_res, fpu_ready,
    input  req_ack, rsp_valid, rsp_res, rsp_err, rsp_cycles, busy,
           fpu_start, fpu_operation, fpu_inpA, fpu_inpB
  );
endinterface

// File: rtl/fpu_share_arbiter.sv
// Round-robin sharing of one start/ready FPU among NREQ clients, with a
// WAIT-cycle counter and timeout abort. Every output comes straight from a flop.
module fpu_share_arbiter #(
  parameter int REG_SIZE = 32,
  parameter int OP_BITS  = 2,
  parameter int NREQ     = 4,
  parameter int TIMEOUT  = 63
) (
  input  logic               clk,
  input  logic               rst_n,
  fpu_share_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d, win_q, win_d;
  logic [OP_BITS-1:0]  op_q, op_d;
  logic [REG_SIZE-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [NREQ-1:0]     ack_q, ack_d, rspv_q, rspv_d;
  logic [5:0]          cnt_q, cnt_d, cyc_q, cyc_d, cnt_inc;
  logic                start_q, start_d, err_q, err_d, busy_q, busy_d, ready_q;
  logic                found, rise;
  logic [IW-1:0]       pick, idx;

  // First requester strictly after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = '0;
    for (int j = 1; j <= NREQ; j++) begin
      idx = IW'((int'(ptr_q) + j) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign rise    = bus.fpu_ready & ~ready_q;
  assign cnt_inc = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    rspv_d  = '0;
    start_d = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        win_d      = pick;
        ptr_d      = pick;
        op_d       = bus.req_op[pick];
        a_d        = bus.req_a[pick];
        b_d        = bus.req_b[pick];
        start_d    = 1'b1;
        ack_d[pick] = 1'b1;
        state_d    = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // A ready edge beats a coincident timeout.
        if (rise) begin
          res_d         = bus.fpu_res;
          err_d         = 1'b0;
          cyc_d         = cnt_inc;
          rspv_d[win_q] = 1'b1;
          state_d       = RESP;
        end else if (cnt_inc >= 6'(TIMEOUT)) begin
          res_d         = '0;
          err_d         = 1'b1;
          cyc_d         = cnt_inc;
          rspv_d[win_q] = 1'b1;
          state_d       = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      win_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      rspv_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rspv_q  <= rspv_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      ready_q <= bus.fpu_ready;
    end
  end

  assign bus.req_ack       = ack_q;
  assign bus.rsp_valid     = rspv_q;
  assign bus.rsp_res       = res_q;
  assign bus.rsp_err       = err_q;
  assign bus.rsp_cycles    = cyc_q;
  assign bus.busy          = busy_q;
  assign bus.fpu_start     = start_q;
  assign bus.fpu_operation = op_q;
  assign bus.fpu_inpA      = a_q;
  assign bus.fpu_inpB      = b_q;
endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Directed and random stimulus for fpu_share_arbiter, checked every cycle against
// a transaction-level model (grant, wait count, response) plus directed scenario checks.
module tb_fpu_share_arbiter;
  localparam int REG_SIZE = 32;
  localparam int OP_BITS  = 2;
  localparam int NREQ     = 4;
  localparam int TIMEOUT  = 63;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_share_arbiter_if #(.REG_SIZE(REG_SIZE), .OP_BITS(OP_BITS), .NREQ(NREQ)) bus();
  fpu_share_arbiter #(.REG_SIZE(REG_SIZE), .OP_BITS(OP_BITS), .NREQ(NREQ), .TIMEOUT(TIMEOUT))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0, n_fail = 0;

  // reference model of the transaction in flight
  bit                  m_busy, m_rsp, m_rdy_prev;
  int                  m_ptr, m_win, m_t;
  logic [OP_BITS-1:0]  m_op;
  logic [REG_SIZE-1:0] m_a, m_b, m_res;
  logic                m_err;
  logic [5:0]          m_cyc;

  // stimulus knobs and bookkeeping
  logic [NREQ-1:0] hold_mask;
  bit  stuck, rand_lat, rand_arr, factive;
  int  lat, cur_lat, fcnt, start_cnt;
  int  rsp_cnt [NREQ];
  int  grants[$];
  logic [REG_SIZE-1:0] last_res;
  logic                last_err;
  logic [5:0]          last_cyc;

  function automatic logic [REG_SIZE-1:0] fpu_fn(logic [OP_BITS-1:0] op, logic [REG_SIZE-1:0] a,
                                                 logic [REG_SIZE-1:0] b);
    // sqrt via the exponent-halving bit trick; divide is just a distinct mix
    return op[0] ? (a >> 1) + 32'h1fc0_0000 : (a - b) ^ 32'h5a5a_0000;
  endfunction

  function automatic int rr_pick(logic [NREQ-1:0] v, int ptr);
    for (int j = 1; j <= NREQ; j++)
      if (v[(ptr + j) % NREQ]) return (ptr + j) % NREQ;
    return -1;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(string tag);
    n_chk++;
    n_fail++;
    $error("FAIL %s: cycle budget expired", tag);
  endtask

  task automatic new_req(int i, logic [OP_BITS-1:0] op, logic [REG_SIZE-1:0] a, logic [REG_SIZE-1:0] b);
    bus.req_valid[i] = 1'b1;
    bus.req_op[i]    = op;
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
  endtask

  task automatic model_reset();
    m_busy = 0; m_rsp = 0; m_rdy_prev = 0; m_ptr = NREQ - 1; m_win = 0; m_t = 0;
    m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_err = 1'b0; m_cyc = '0;
    factive = 0; fcnt = 0;
  endtask

  task automatic chk_zero();
    chk("rst_ack",   64'(bus.req_ack), 64'd0);
    chk("rst_rspv",  64'(bus.rsp_valid), 64'd0);
    chk("rst_res",   64'(bus.rsp_res), 64'd0);
    chk("rst_err",   64'(bus.rsp_err), 64'd0);
    chk("rst_cyc",   64'(bus.rsp_cycles), 64'd0);
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_start", 64'(bus.fpu_start), 64'd0);
    chk("rst_op",    64'(bus.fpu_operation), 64'd0);
    chk("rst_a",     64'(bus.fpu_inpA), 64'd0);
    chk("rst_b",     64'(bus.fpu_inpB), 64'd0);
  endtask

  // One clock: model consumes the inputs present at the edge, outputs checked #1 later,
  // then requesters and the FPU model react.
  task automatic step();
    logic [NREQ-1:0]               v, e_ack, e_rv;
    logic [NREQ-1:0][OP_BITS-1:0]  vop;
    logic [NREQ-1:0][REG_SIZE-1:0] va, vb;
    logic rdy, e_start;
    int   n;
    bit   done;
    v = bus.req_valid; vop = bus.req_op; va = bus.req_a; vb = bus.req_b; rdy = bus.fpu_ready;
    @(posedge clk); #1;
    e_ack = '0; e_rv = '0; e_start = 1'b0;
    if (!m_busy) begin
      if (v != '0) begin
        m_win = rr_pick(v, m_ptr); m_ptr = m_win; m_busy = 1; m_t = 0; m_rsp = 0;
        m_op = vop[m_win]; m_a = va[m_win]; m_b = vb[m_win];
        e_ack[m_win] = 1'b1; e_start = 1'b1;
      end
    end else begin
      m_t++;
      if (m_rsp) begin
        m_busy = 0; m_rsp = 0;
      end else if (m_t >= 2) begin
        n = m_t - 1; done = 0;
        if (rdy && !m_rdy_prev) begin m_res = fpu_fn(m_op, m_a, m_b); m_err = 1'b0; done = 1; end
        else if (n >= TIMEOUT) begin m_res = '0; m_err = 1'b1; done = 1; end
        if (done) begin m_cyc = 6'(n); m_rsp = 1; e_rv[m_win] = 1'b1; end
      end
    end
    m_rdy_prev = rdy;

    chk("ack",   64'(bus.req_ack), 64'(e_ack));
    chk("start", 64'(bus.fpu_start), 64'(e_start));
    chk("rspv",  64'(bus.rsp_valid), 64'(e_rv));
    chk("busy",  64'(bus.busy), 64'(m_busy));
    chk("res",   64'(bus.rsp_res), 64'(m_res));
    chk("err",   64'(bus.rsp_err), 64'(m_err));
    chk("cyc",   64'(bus.rsp_cycles), 64'(m_cyc));
    chk("fop",   64'(bus.fpu_operation), 64'(m_op));
    chk("fa",    64'(bus.fpu_inpA), 64'(m_a));
    chk("fb",    64'(bus.fpu_inpB), 64'(m_b));

    if (bus.fpu_start) start_cnt++;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.rsp_valid[i]) begin
        rsp_cnt[i]++; last_res = bus.rsp_res; last_err = bus.rsp_err; last_cyc = bus.rsp_cycles;
      end
      if (bus.req_ack[i]) begin
        grants.push_back(i);
        if (hold_mask[i]) new_req(i, 2'(i), $urandom, $urandom);
        else bus.req_valid[i] = 1'b0;
      end
    end
    if (rand_arr)
      for (int i = 0; i < NREQ; i++)
        if (!bus.req_valid[i] && $urandom_range(3) == 0)
          new_req(i, 2'($urandom_range(3)), $urandom, $urandom);

    if (bus.fpu_start) begin
      factive = 1; fcnt = 0; cur_lat = rand_lat ? int'($urandom_range(1, 70)) : lat;
    end else if (factive) fcnt++;
    bus.fpu_ready = stuck ? 1'b1 : (factive && cur_lat > 0 && fcnt == cur_lat);
    bus.fpu_res   = fpu_fn(bus.fpu_operation, bus.fpu_inpA, bus.fpu_inpB);
  endtask

  task automatic drain(string tag, int budget);
    int c = 0;
    while ((m_busy || bus.req_valid != '0) && c < budget) begin step(); c++; end
    if (m_busy || bus.req_valid != '0) bound_fail(tag);
    step(); step();
  endtask

  task automatic clear_stats();
    grants.delete(); start_cnt = 0;
    for (int i = 0; i < NREQ; i++) rsp_cnt[i] = 0;
  endtask

  initial begin
    int c;
    bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.fpu_res = '0; bus.fpu_ready = 1'b0;
    hold_mask = '0; stuck = 0; rand_lat = 0; rand_arr = 0; lat = 3; cur_lat = 3;
    last_res = '0; last_err = 1'b0; last_cyc = '0;
    model_reset(); clear_stats();
    #3 chk_zero();
    #9 rst_n = 1'b1;

    // all four divides at once: pointer starts at NREQ-1 so order is 0,1,2,3
    for (int i = 0; i < NREQ; i++) new_req(i, 2'b00, $urandom, $urandom);
    drain("all4_drain", 200);
    chk("all4_ngrants", 64'(grants.size()), 64'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("all4_order", 64'(grants[i]), 64'(i));
    chk("all4_starts", 64'(start_cnt), 64'd4);
    for (int i = 0; i < NREQ; i++) chk("all4_rspcnt", 64'(rsp_cnt[i]), 64'd1);

    // requester 0 held continuously alongside requester 2
    clear_stats(); hold_mask = 4'b0101;
    new_req(0, 2'b00, $urandom, $urandom); new_req(2, 2'b00, $urandom, $urandom);
    c = 0;
    while (grants.size() < 4 && c < 200) begin step(); c++; end
    if (grants.size() < 4) bound_fail("fair_grants");
    hold_mask = '0; bus.req_valid = '0;
    drain("fair_drain", 200);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("fair_order", 64'(grants[i]), (i % 2 == 0) ? 64'd0 : 64'd2);

    // single sqrt of 4.0 with a 20-cycle FPU
    clear_stats(); lat = 20;
    new_req(0, 2'b01, 32'h4080_0000, $urandom);
    drain("sqrt_drain", 100);
    chk("sqrt_starts", 64'(start_cnt), 64'd1);
    chk("sqrt_rspcnt", 64'(rsp_cnt[0]), 64'd1);
    chk("sqrt_res", 64'(last_res), 64'h4000_0000);
    chk("sqrt_err", 64'(last_err), 64'd0);
    chk("sqrt_cyc", 64'(last_cyc), 64'd20);

    // FPU never answers, then a normal request
    clear_stats(); lat = 0;
    new_req(1, 2'b00, $urandom, $urandom);
    drain("to_drain", 150);
    chk("to_err", 64'(last_err), 64'd1);
    chk("to_res", 64'(last_res), 64'd0);
    chk("to_cyc", 64'(last_cyc), 64'd63);
    lat = 5;
    new_req(3, 2'b10, $urandom, $urandom);
    drain("after_to_drain", 100);
    chk("after_to_err", 64'(last_err), 64'd0);
    chk("after_to_cyc", 64'(last_cyc), 64'd5);

    // ready stuck high before issue never forms an edge
    stuck = 1; bus.fpu_ready = 1'b1; step(); step();
    new_req(2, 2'b01, $urandom, $urandom);
    drain("stuck_drain", 150);
    chk("stuck_err", 64'(last_err), 64'd1);
    chk("stuck_cyc", 64'(last_cyc), 64'd63);
    stuck = 0; bus.fpu_ready = 1'b0; step();

    // random traffic with latencies straddling the timeout
    rand_lat = 1; rand_arr = 1;
    repeat (800) step();
    rand_arr = 0;
    drain("rand_drain", 600);
    rand_lat = 0;

    // reset in the middle of WAIT
    lat = 40; clear_stats();
    new_req(1, 2'b00, $urandom, $urandom);
    c = 0;
    while (!(m_busy && m_t >= 6) && c < 50) begin step(); c++; end
    if (!(m_busy && m_t >= 6)) bound_fail("mid_wait");
    rst_n = 1'b0; #1;
    chk_zero();
    bus.req_valid = '0; bus.fpu_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk_zero();
    clear_stats(); lat = 4;
    for (int i = 0; i < NREQ; i++) new_req(i, 2'($urandom_range(3)), $urandom, $urandom);
    drain("post_rst_drain", 200);
    chk("post_rst_first", 64'(grants.size() > 0 ? grants[0] : -1), 64'd0);
    chk("post_rst_rspcnt1", 64'(rsp_cnt[1]), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_share_arbiter.md
# fpu_share_arbiter

Round-robin scheduler that shares one FPU (divide/sqrt unit with start/ready handshake) between NREQ requesters. It accepts one request at a time, sequences the FPU start pulse, waits for the FPU ready edge and returns the result to the winning requester. It also reports per-operation cycle count and a timeout error. Sits between client blocks and the single FPU instance.

## Interface
- REG_SIZE, 32, operand/result width
- OP_BITS, 2, operation code width; bit 0 = 1 is sqrt (operand B unused), 0 is divide
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 63, max WAIT cycles before abort (1..63)

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- req_valid  in  NREQ  per-requester request level; held until matching req_ack
- req_op  in  NREQ*OP_BITS  packed opcodes; slice i belongs to requester i
- req_a  in  NREQ*REG_SIZE  packed operand A
- req_b  in  NREQ*REG_SIZE  packed operand B
- req_ack  out  NREQ  one-hot, one-cycle pulse: request captured
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: result for requester i
- rsp_res  out  REG_SIZE  result, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- rsp_cycles  out  6  WAIT cycles consumed, valid with rsp_valid
- busy  out  1  high in every state except IDLE
- fpu_start  out  1  start pulse to FPU
- fpu_operation  out  OP_BITS  opcode to FPU
- fpu_inpA  out  REG_SIZE  operand A to FPU
- fpu_inpB  out  REG_SIZE  operand B to FPU
- fpu_res  in  REG_SIZE  FPU result
- fpu_ready  in  1  FPU done level

## Operation
- All outputs registered; reset value 0 for every output; state = IDLE; rr pointer = NREQ-1; ready_q = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, winner = first set bit scanning from pointer+1 upward with wrap. Latch winner index, opcode, A, B into fpu_* regs; pointer <= winner; -> ISSUE. No request: stay.
- ISSUE (one cycle): fpu_start = 1, req_ack[winner] = 1; counter cleared; -> WAIT.
- WAIT: fpu_start = 0; fpu_operation/inpA/inpB held stable until IDLE.
  - Counter increments each cycle, saturating at 63.
  - Rising ready (fpu_ready & ~ready_q) -> capture fpu_res, err = 0 -> RESP.
  - Counter reaching TIMEOUT with no edge -> res = 0, err = 1 -> RESP.
  - Edge and timeout in the same cycle: edge wins.
- RESP (one cycle): rsp_valid[winner] = 1, rsp_res, rsp_err and rsp_cycles driven; -> IDLE.
  - rsp_res/rsp_err/rsp_cycles hold their value until the next RESP.
- ready_q samples fpu_ready every cycle in all states. A ready level already high on WAIT entry is not an edge; that case ends in timeout.
- Requests arriving while busy stay pending; req_valid dropped before ack is not served.
- sqrt ops: fpu_inpB is still loaded from req_b; the FPU ignores it.
- rst_n low in any state: immediate return to reset values, in-flight op discarded, no rsp_valid.

## Timing
- Request sampled in IDLE at edge k: ISSUE during cycle k..k+1 (fpu_start and req_ack high), WAIT from edge k+1.
- FPU ready rises and is sampled at edge m: RESP cycle m..m+1; IDLE at edge m+1. Minimum IDLE-to-IDLE time is 4 cycles.
- rsp_cycles = number of WAIT edges up to and including the edge that detected ready or timeout.
- Back-to-back: a new grant is possible at the first IDLE edge after RESP.
- Fairness: with all requests continuously asserted, the grant order is 0,1,…,NREQ-1 and repeats.

## Test plan
- Single sqrt: req_valid=0001, op=01, A=0x40800000; FPU model ready after 20 cycles, res=0x40000000 -> ack[0] pulse, one fpu_start pulse, rsp_valid=0001, rsp_res=0x40000000, rsp_err=0, rsp_cycles=20.
- All four divide requests asserted together -> grants 0,1,2,3 in order. Each rsp_valid bit pulses once with its own requester's result; fpu_start pulses exactly 4 times.
- req_valid[0] held high continuously plus req_valid[2] -> alternating grants 0,2,0,2; requester 2 is never starved.
- FPU never raises ready, TIMEOUT=63 -> rsp_valid for the winner at WAIT edge 63, rsp_err=1, rsp_res=0, rsp_cycles=63; next request is then served normally.
- fpu_ready stuck high from before ISSUE -> no edge detected; timeout response with rsp_err=1.
- rst_n pulsed low mid-WAIT -> all outputs 0 immediately and no rsp_valid. After release, requester 0 wins first because the pointer resets to NREQ-1.
